// File: rtl/soda_pkg.sv
// Shared soda-machine constants: ASCII codes used by the keypad/UART parser
// and the parser state encoding.
package soda_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } parser_state_e;

  // acc*10 as two shifts and an add; the result keeps the accumulator width.
  function automatic logic [9:0] mul10(input logic [9:0] a);
    return (a << 3) + (a << 1);
  endfunction

endpackage

// File: rtl/ascii_char_class.sv
// Combinational ASCII character classifier for the decimal entry parser.
module ascii_char_class
  import soda_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       is_digit,
  output logic       is_space,
  output logic       is_cr,
  output logic       is_dot,
  output logic [3:0] digit
);

  assign is_digit = (char_data >= ASCII_ZERO) && (char_data <= ASCII_NINE);
  assign is_space = (char_data == ASCII_SPACE);
  assign is_cr    = (char_data == ASCII_CR);
  assign is_dot   = (char_data == ASCII_DOT);
  // Codes 0x30..0x39 carry the digit value in their low nibble.
  assign digit    = is_digit ? char_data[3:0] : 4'd0;

endmodule

// File: rtl/ascii_dec_parser.sv
// Streaming ASCII-decimal to 8-bit binary converter (cents) with error pulse.
// Optional feature macro: ASCII_PARSE_DOT_EN (accept one '.' as a separator).
module ascii_dec_parser
  import soda_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  // Handshake: a character transfers on a rising edge where char_valid and
  // char_ready are both high; the source holds char_data until then.
  input  logic          char_valid,
  input  logic [7:0]    char_data,
  output logic          char_ready,
  output logic [7:0]    value,
  output logic          value_valid,
  output logic          err,
  output logic          busy,
  output parser_state_e state_dbg
);

  localparam logic [1:0] MAX_D = 2'(MAX_DIGITS);

  parser_state_e state;
  logic [9:0]    acc;
  logic [1:0]    ndig;
  logic          bad;
`ifdef ASCII_PARSE_DOT_EN
  logic          dot_seen;
`endif

  logic          is_digit, is_space, is_cr, is_dot;
  logic [3:0]    digit;
  logic          xfer;
  logic          entry_ok;
  logic [9:0]    acc_next;

  ascii_char_class u_class (
    .char_data (char_data),
    .is_digit  (is_digit),
    .is_space  (is_space),
    .is_cr     (is_cr),
    .is_dot    (is_dot),
    .digit     (digit)
  );

  assign xfer      = char_valid && char_ready;
  assign acc_next  = mul10(acc) + {6'd0, digit};
  // An entry with no digits (still in IDLE) is rejected at the terminator.
  assign entry_ok  = !bad && (state == ACCUM) && (acc <= 10'd255);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= 10'd0;
      ndig        <= 2'd0;
      bad         <= 1'b0;
      value       <= 8'h00;
      value_valid <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      char_ready  <= 1'b0;
`ifdef ASCII_PARSE_DOT_EN
      dot_seen    <= 1'b0;
`endif
    end else begin
      value_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          char_ready <= 1'b1;
          if (xfer) begin
            if (is_cr) begin
              state      <= RESULT;
              char_ready <= 1'b0;
              if (entry_ok) begin
                value_valid <= 1'b1;
                value       <= acc[7:0];
              end else begin
                err <= 1'b1;
              end
            end else if (is_digit) begin
              if (ndig == MAX_D) begin
                bad <= 1'b1;
              end else begin
                acc   <= acc_next;
                ndig  <= ndig + 2'd1;
                state <= ACCUM;
                busy  <= 1'b1;
              end
`ifdef ASCII_PARSE_DOT_EN
            end else if (is_dot) begin
              if (dot_seen) bad <= 1'b1;
              dot_seen <= 1'b1;
`else
            end else if (is_dot) begin
              bad <= 1'b1;
`endif
            end else if (!is_space) begin
              bad <= 1'b1;
            end
          end
        end
        RESULT: begin
          acc        <= 10'd0;
          ndig       <= 2'd0;
          bad        <= 1'b0;
          busy       <= 1'b0;
          char_ready <= 1'b1;
          state      <= IDLE;
`ifdef ASCII_PARSE_DOT_EN
          dot_seen   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Scoreboard bench for ascii_dec_parser: directed entries, a mid-entry reset
// and random entries checked against a string-level reference model.
module tb_ascii_dec_parser;
  import soda_pkg::*;

  typedef byte unsigned bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic [7:0]    value;
  logic          value_valid;
  logic          err;
  logic          busy;
  parser_state_e state_dbg;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [8:0]    exp_q[$];   // {is_err, expected value}
  logic [7:0]    last_value = 8'h00;
  logic          armed;
  bit            gaps_en = 1'b0;

  ascii_dec_parser #(.MAX_DIGITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry rules applied to the whole character string at once.
  function automatic logic [8:0] model(input bq_t q);
    int   digits = 0;
    int   dots = 0;
    int   illegal = 0;
    int   v = 0;
    logic rej;
    foreach (q[i]) begin
      if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
        digits++;
        if (digits <= 3) v = v * 10 + int'(q[i] - 8'h30);
      end else if (q[i] == 8'h2E) begin
        dots++;
      end else if (q[i] != 8'h20) begin
        illegal++;
      end
    end
`ifdef ASCII_PARSE_DOT_EN
    rej = (illegal != 0) || (dots > 1);
`else
    rej = (illegal != 0) || (dots != 0);
`endif
    rej = rej || (digits == 0) || (digits > 3) || (v > 255);
    return rej ? {1'b1, last_value} : {1'b0, 8'(v)};
  endfunction

  // ---------------- driver ----------------
  task automatic send_char(input logic [7:0] c);
    int w = 0;
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      char_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    char_valid = 1'b1;
    char_data  = c;
    while (!char_ready && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!char_ready) begin
      chk("ready_timeout", int'(char_ready), 1);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_entry(input bq_t q);
    logic [8:0] e;
    e = model(q);
    exp_q.push_back(e);
    last_value = e[7:0];
    foreach (q[i]) send_char(q[i]);
    send_char(ASCII_CR);
  endtask

  task automatic run_str(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    run_entry(q);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_value_valid"}, int'(value_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_char_ready"}, int'(char_ready), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (value_valid || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({value_valid, err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", int'({value_valid, err}), e[8] ? 1 : 2);
          chk("value", int'(value), int'(e[7:0]));
          chk("ready_low_in_result", int'(char_ready), 0);
        end
      end else if (armed) begin
        chk("ready_high", int'(char_ready), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bq_t q;
    int  len;
    int  r;
    byte unsigned c;
    byte unsigned others[5] = '{8'h41, 8'h7A, 8'h2F, 8'h3A, 8'h2B};

    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed entries with char_valid held high.
    run_str("125");
    run_str("256");
    run_str("007");
    run_str("");
    run_str(" 9 ");
    run_str("1234");
    run_str("1A2");
    run_str("1.25");
    run_str("1..5");
    run_str("1.5");
    run_str("255");
    run_str("0");
    drain();
    chk("idle_after_bad", int'(state_dbg), int'(IDLE));

    // Reset in the middle of an entry.
    char_valid = 1'b0;
    @(posedge clk);
    #1;
    send_char("1");
    send_char("2");
    char_valid = 1'b0;
    @(negedge clk);
    chk("busy_mid_entry", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    last_value = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_str("3");
    drain();

    // Random entries with random valid gaps.
    gaps_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      q = {};
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      c = 8'(8'h30 + $urandom_range(0, 9));
        else if (r == 6) c = 8'h20;
        else if (r == 7) c = 8'h2E;
        else if (r == 8) c = others[$urandom_range(0, 4)];
        else begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h0D) c = 8'h41;
        end
        q.push_back(c);
      end
      run_entry(q);
    end
    char_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Streaming ASCII-decimal to binary converter: the inverse of the display path that turns binary amounts into BCD and then into ASCII digit codes. It accepts one ASCII character per handshake from the keypad/UART front end, accumulates up to three decimal digits, and on a carriage return emits an 8-bit binary value (cents) for the soda-machine controller, e.g. to load `cost` or `coins`. Malformed or out-of-range entries are reported with an error pulse instead of a value.

## Interface
- `MAX_DIGITS`, 3: maximum number of decimal digits accepted per entry (1..3).
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `char_valid` in 1: `char_data` is valid this cycle.
- `char_data` in 8: ASCII character.
- `char_ready` out 1: parser can accept a character this cycle. A transfer occurs when `char_valid && char_ready`.
- `value` out 8: parsed binary value. Holds its last result between entries.
- `value_valid` out 1: one-cycle pulse; `value` is new.
- `err` out 1: one-cycle pulse; the entry was rejected.
- `busy` out 1: at least one digit has been accepted since the last terminator.

## Operation
- **Character classes** (after a transfer):
  - digit 8'h30–8'h39: `acc <= acc*10 + (char-8'h30)`, `ndig++`.
  - space 8'h20: ignored.
  - CR 8'h0D: terminator.
  - dot 8'h2E: see Configuration.
  - anything else: sets sticky `bad`.
- **Accumulator:** 10 bits wide, so 999 fits. Multiply by 10 is implemented as `(acc<<3)+(acc<<1)`.
- **States:**
  - IDLE: `ndig == 0`. A digit moves to ACCUM; CR with no digits moves to RESULT with an error; space stays in IDLE.
  - ACCUM: keeps collecting. A digit when `ndig == MAX_DIGITS` sets `bad`; CR moves to RESULT.
  - RESULT: lasts one cycle, with `char_ready = 0`. Emits exactly one of:
    - `value_valid`, with `value <= acc[7:0]`, if `!bad && acc <= 255`;
    - `err`, otherwise, leaving `value` unchanged.
  - RESULT then clears `acc`, `ndig` and `bad`, and returns to IDLE.
- Once `bad` is set, characters are still consumed up to CR. Errors are reported only at the terminator.
- **Reset values:** `value = 8'h00`, `value_valid = 0`, `err = 0`, `busy = 0`, `char_ready = 0` during reset and `1` from the first cycle after release; internal `acc = 0`, `ndig = 0`, `bad = 0`, state IDLE.
- **Reset mid-entry:** the partial entry is discarded silently, with no pulse.

## Timing
- `char_ready` is 1 in IDLE and ACCUM, and 0 only in the RESULT cycle.
- Latency: a CR accepted on edge N produces `value_valid`/`err` high during cycle N+1. The next character can be accepted on edge N+2.
- `value` is registered and updates on the same edge that raises `value_valid`.
- Throughput: one character per cycle while `char_ready` is high.
- `char_data` is sampled only on a transfer. If `char_valid` is high while `char_ready` is low, the source must hold the character.
- `busy` is registered: high from the edge that accepts the first digit until the edge that leaves RESULT.

## Configuration
- `ASCII_PARSE_DOT_EN` defined: dot (8'h2E) is accepted and ignored as a visual separator, so "1.25" parses as 125. At most one dot is allowed per entry; a second dot sets `bad`.
- `ASCII_PARSE_DOT_EN` not defined: dot is treated like any other illegal character and sets `bad`.

## Structure
- **Shared package `soda_pkg`:** constants `ASCII_ZERO`, `ASCII_NINE`, `ASCII_SPACE` (8'h20, matching the display blank code), `ASCII_CR`, `ASCII_DOT`; parser state enum {IDLE, ACCUM, RESULT}.
- **Sub-module `ascii_char_class`:** combinational. Maps `char_data` to {is_digit, is_space, is_cr, is_dot, digit[3:0]}.
- Parser FSM, accumulator and output registers live in `ascii_dec_parser`.

## Test plan
- Reset, then stream "1","2","5",CR with `char_valid` held high → `value_valid` pulse exactly once, `value = 8'd125`, `err` stays 0, `char_ready` low for one cycle after CR.
- Stream "2","5","6",CR → `err` pulse, `value` keeps the previous 125. Stream "0","0","7",CR → `value = 7`.
- Stream CR alone → `err` pulse. Stream " ","9"," ",CR → `value = 9`.
- Stream "1","2","3","4",CR → `err` (too many digits). Stream "1","A","2",CR → `err`; the CR is still consumed and the parser is back in IDLE.
- With `ASCII_PARSE_DOT_EN`: "1",".","2","5",CR → `value = 125`; "1",".",".","5",CR → `err`. Without the macro: "1",".","5",CR → `err`.
- Assert `rst_n` low after "1","2" → all outputs return to their reset values. After release, "3",CR → `value = 3` with no stale digits.
